// File: rtl/conv_sequencer_if.sv
// Handshake/bus bundle between the convolution sequencer and the memory controller ALU port.
// The master modport is the sequencer side; the slave modport is the controller/top side.
interface conv_sequencer_if #(
    parameter int AW = 17
);
    logic          start;
    logic          pass_thru;
    logic          hold;
    logic [1:0]    kernel_sel_in;
    logic [1:0]    kernel_sel;
    logic [AW-1:0] raddr_alu;
    logic [AW-1:0] waddr_alu;
    logic          wen_alu;
    logic          border_alu;
    logic          busy;
    logic          done;

    modport master (
        input  start, pass_thru, hold, kernel_sel_in,
        output kernel_sel, raddr_alu, waddr_alu, wen_alu, border_alu, busy, done
    );

    modport slave (
        output start, pass_thru, hold, kernel_sel_in,
        input  kernel_sel, raddr_alu, waddr_alu, wen_alu, border_alu, busy, done
    );
endinterface

// File: rtl/conv_sequencer.sv
// Frame scheduler: walks one frame in raster order, issuing read addresses and, ALU_LAT
// cycles later, the matching frame-buffer writes. The kernel selection is frozen per pass.
module conv_sequencer #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int AW      = 17,
    parameter int ALU_LAT = 2
) (
    input logic              sys_clk,
    input logic              rst,
    conv_sequencer_if.master bus
);
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [AW-1:0] A_LAST = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic          border;
    } entry_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [1:0]    kernel_q, kernel_d;
    logic          wen_q, wen_d;
    logic          border_q, border_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    entry_t        line_q [ALU_LAT];
    entry_t        line_d [ALU_LAT];

    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic [AW-1:0] addr_cur;
    logic          issue;
    logic          line_valid;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case leaves it unassigned (no latches).
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        raddr_d    = raddr_q;
        kernel_d   = kernel_q;
        x_cur      = x_q;
        y_cur      = y_q;
        addr_cur   = addr_q;
        issue      = 1'b0;
        line_valid = 1'b0;
        for (int i = 0; i < ALU_LAT; i++) begin
            line_valid = line_valid | line_q[i].valid;
        end

        case (state_q)
            IDLE: begin
                // The accepting edge already issues pixel 0 so raddr_alu is valid one cycle after start.
                if (bus.start && !bus.pass_thru) begin
                    state_d  = RUN;
                    kernel_d = bus.kernel_sel_in;
                    x_cur    = '0;
                    y_cur    = '0;
                    addr_cur = '0;
                    x_d      = '0;
                    y_d      = '0;
                    addr_d   = '0;
                    issue    = !bus.hold;
                end
            end
            RUN:     issue = !bus.hold;
            DRAIN:   if (!line_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            raddr_d = addr_cur;
            addr_d  = addr_cur + AW'(1);
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = y_cur + YW'(1);
            end else begin
                x_d = x_cur + XW'(1);
            end
            if (addr_cur == A_LAST) state_d = DRAIN;
        end

        line_d[0].valid  = issue;
        line_d[0].addr   = addr_cur;
        line_d[0].border = issue & ((x_cur == '0) | (x_cur == X_LAST) |
                                    (y_cur == '0) | (y_cur == Y_LAST));
        for (int i = 1; i < ALU_LAT; i++) begin
            line_d[i] = line_q[i-1];
        end

        wen_d    = line_q[ALU_LAT-1].valid;
        waddr_d  = line_q[ALU_LAT-1].addr;
        border_d = line_q[ALU_LAT-1].border;
        busy_d   = (state_d == RUN) || (state_d == DRAIN);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            kernel_q <= '0;
            wen_q    <= 1'b0;
            border_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            // NOTE: the delay line is reset on purpose so an aborted pass can never retire a stale write.
            for (int i = 0; i < ALU_LAT; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            kernel_q <= kernel_d;
            wen_q    <= wen_d;
            border_q <= border_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            line_q   <= line_d;
        end
    end

    assign bus.raddr_alu  = raddr_q;
    assign bus.waddr_alu  = waddr_q;
    assign bus.wen_alu    = wen_q;
    assign bus.border_alu = border_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.kernel_sel = kernel_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a per-cycle vector table for a full 4x3 pass plus
// hand-written hold, gating, mid-pass reset and a 320x240 / ALU_LAT=5 latency sweep.
module tb_conv_sequencer;
    logic sys_clk = 1'b0;
    logic rst;

    always #5 sys_clk = ~sys_clk;

    conv_sequencer_if #(.AW(17)) sb ();
    conv_sequencer_if #(.AW(17)) bb ();

    conv_sequencer #(.IMG_W(4), .IMG_H(3), .AW(17), .ALU_LAT(2)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (sb.master)
    );

    conv_sequencer #(.IMG_W(320), .IMG_H(240), .AW(17), .ALU_LAT(5)) dut_big (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bb.master)
    );

    typedef struct {
        logic       start;
        logic       pass_thru;
        logic       hold;
        logic [1:0] ksel_in;
        int         e_raddr;
        logic       e_busy;
        logic       e_wen;
        int         e_waddr;
        logic       e_border;
        logic       e_done;
        logic [1:0] e_ksel;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    logic [16:0] raddr_log [32];
    logic        wen_log   [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One small-frame pass starting now (cycle 0); hold_mask bit c drives hold in cycle c.
    task automatic run_pass(input string name, input logic [31:0] hold_mask, input int exp_done);
        int next_addr = 0;
        int done_cyc  = -1;
        for (int c = 0; c < 32; c++) begin
            sb.start = (c == 0);
            sb.hold  = hold_mask[c];
            raddr_log[c] = sb.raddr_alu;
            wen_log[c]   = sb.wen_alu;
            if (sb.wen_alu) begin
                check($sformatf("%s waddr", name), 32'(sb.waddr_alu), next_addr);
                next_addr++;
            end
            if (sb.done && done_cyc < 0) done_cyc = c;
            step();
        end
        sb.start = 1'b0;
        sb.hold  = 1'b0;
        check($sformatf("%s write count", name), next_addr, 12);
        check($sformatf("%s done cycle", name), done_cyc, exp_done);
    endtask

    initial begin
        vec_t vecs [17];
        int   active;
        int   first_wen;
        int   writes;
        int   seq_err;
        int   done_cyc;

        vecs[0]  = '{1, 0, 0, 2,  0, 0, 0,  0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 2,  0, 1, 0,  0, 0, 0, 2};
        vecs[2]  = '{0, 0, 0, 2,  1, 1, 0,  0, 0, 0, 2};
        vecs[3]  = '{0, 0, 0, 2,  2, 1, 1,  0, 1, 0, 2};
        vecs[4]  = '{0, 0, 0, 2,  3, 1, 1,  1, 1, 0, 2};
        vecs[5]  = '{0, 0, 0, 3,  4, 1, 1,  2, 1, 0, 2};
        vecs[6]  = '{1, 0, 0, 3,  5, 1, 1,  3, 1, 0, 2};
        vecs[7]  = '{0, 0, 0, 3,  6, 1, 1,  4, 1, 0, 2};
        vecs[8]  = '{0, 1, 0, 3,  7, 1, 1,  5, 0, 0, 2};
        vecs[9]  = '{0, 1, 0, 3,  8, 1, 1,  6, 0, 0, 2};
        vecs[10] = '{0, 0, 0, 3,  9, 1, 1,  7, 1, 0, 2};
        vecs[11] = '{0, 0, 0, 3, 10, 1, 1,  8, 1, 0, 2};
        vecs[12] = '{0, 0, 0, 3, 11, 1, 1,  9, 1, 0, 2};
        vecs[13] = '{0, 0, 0, 3, 11, 1, 1, 10, 1, 0, 2};
        vecs[14] = '{0, 0, 0, 3, 11, 1, 1, 11, 1, 0, 2};
        vecs[15] = '{0, 0, 0, 3, 11, 0, 0,  0, 0, 1, 2};
        vecs[16] = '{0, 0, 0, 3, 11, 0, 0,  0, 0, 0, 2};

        rst = 1'b1;
        sb.start = 1'b0; sb.pass_thru = 1'b0; sb.hold = 1'b0; sb.kernel_sel_in = 2'd1;
        bb.start = 1'b0; bb.pass_thru = 1'b0; bb.hold = 1'b0; bb.kernel_sel_in = 2'd0;
        repeat (3) step();

        check("reset raddr",  32'(sb.raddr_alu), 0);
        check("reset waddr",  32'(sb.waddr_alu), 0);
        check("reset wen",    32'(sb.wen_alu), 0);
        check("reset border", 32'(sb.border_alu), 0);
        check("reset busy",   32'(sb.busy), 0);
        check("reset done",   32'(sb.done), 0);
        check("reset ksel",   32'(sb.kernel_sel), 0);
        rst = 1'b0;
        step();

        // Basic pass, border pattern, kernel latching, ignored re-start and mid-pass pass_thru.
        for (int c = 0; c < 17; c++) begin
            sb.start         = vecs[c].start;
            sb.pass_thru     = vecs[c].pass_thru;
            sb.hold          = vecs[c].hold;
            sb.kernel_sel_in = vecs[c].ksel_in;
            check($sformatf("c%0d raddr", c), 32'(sb.raddr_alu), vecs[c].e_raddr);
            check($sformatf("c%0d busy", c),  32'(sb.busy), 32'(vecs[c].e_busy));
            check($sformatf("c%0d wen", c),   32'(sb.wen_alu), 32'(vecs[c].e_wen));
            check($sformatf("c%0d done", c),  32'(sb.done), 32'(vecs[c].e_done));
            check($sformatf("c%0d ksel", c),  32'(sb.kernel_sel), 32'(vecs[c].e_ksel));
            if (vecs[c].e_wen) begin
                check($sformatf("c%0d waddr", c),  32'(sb.waddr_alu), vecs[c].e_waddr);
                check($sformatf("c%0d border", c), 32'(sb.border_alu), 32'(vecs[c].e_border));
            end
            step();
        end
        sb.start = 1'b0; sb.pass_thru = 1'b0;
        step();

        // Hold in cycles 4..5: two bubbles, ordered writes, completion two cycles late.
        run_pass("hold", 32'h0000_0030, 17);
        check("hold raddr c4", 32'(raddr_log[4]), 3);
        check("hold raddr c5", 32'(raddr_log[5]), 3);
        check("hold raddr c6", 32'(raddr_log[6]), 3);
        check("hold raddr c7", 32'(raddr_log[7]), 4);
        check("hold wen c6",   32'(wen_log[6]), 1);
        check("hold wen c7",   32'(wen_log[7]), 0);
        check("hold wen c8",   32'(wen_log[8]), 0);
        check("hold wen c9",   32'(wen_log[9]), 1);
        check("hold wen c16",  32'(wen_log[16]), 1);

        // pass_thru blocks start entirely.
        active = 0;
        sb.pass_thru = 1'b1;
        sb.start     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sb.busy || sb.wen_alu || sb.done) active++;
        end
        check("pass_thru activity", active, 0);
        sb.pass_thru = 1'b0;
        sb.start     = 1'b0;
        step();

        // Reset asserted in cycle 7 of a pass.
        sb.kernel_sel_in = 2'd3;
        for (int c = 0; c < 7; c++) begin
            sb.start = (c == 0);
            step();
        end
        rst = 1'b1;
        step();
        check("abort raddr",  32'(sb.raddr_alu), 0);
        check("abort waddr",  32'(sb.waddr_alu), 0);
        check("abort wen",    32'(sb.wen_alu), 0);
        check("abort border", 32'(sb.border_alu), 0);
        check("abort busy",   32'(sb.busy), 0);
        check("abort done",   32'(sb.done), 0);
        check("abort ksel",   32'(sb.kernel_sel), 0);
        rst = 1'b0;
        active = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (sb.wen_alu || sb.busy) active++;
        end
        check("abort no writes", active, 0);
        run_pass("after abort", 32'h0, 15);

        // Latency sweep on the full-size instance.
        first_wen = -1;
        writes    = 0;
        seq_err   = 0;
        done_cyc  = -1;
        for (int c = 0; c < 77000; c++) begin
            bb.start = (c == 0);
            if (bb.wen_alu) begin
                if (first_wen < 0) first_wen = c;
                if (32'(bb.waddr_alu) != writes) seq_err++;
                writes++;
            end
            if (bb.done) begin
                done_cyc = c;
                break;
            end
            step();
        end
        bb.start = 1'b0;
        check("big first wen", first_wen, 6);
        check("big writes", writes, 76800);
        check("big order", seq_err, 0);
        check("big done cycle", done_cyc, 76806);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
